fixed_point_division_ctrl: RTL and testbench

- FSM controller that sequences the 10-bit fixed-point shift/subtract divider datapath: operand registers A and B, the ACC and Q registers, the subtractor, the ACC>=B comparator, the iteration counter and the overflow detector.
- Accepts a start request and drives per-cycle load, shift, subtract and set strobes for N_ITER iterations.
- Reports completion, overflow and divide-by-zero to the surrounding system.
- Sits between the system bus/top level and the divider datapath, which becomes purely strobe-driven.

---
 rtl/fixed_point_division_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_fixed_point_division_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fixed_point_division_ctrl.sv
// fixed_point_division_ctrl
// Sequencing FSM for a shift/subtract fixed-point divider. The datapath is
// purely strobe-driven; this block decides, cycle by cycle, which of its
// registers load, shift, subtract or set a quotient bit. It also tracks the
// iteration index and the sticky overflow / divide-by-zero flags.
module fixed_point_division_ctrl #(
  parameter int N_ITER = 14,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             b_zero,
  input  logic             gT,
  input  logic             ov_in,
  output logic             ld_a,
  output logic             ld_b,
  output logic             acc_clr,
  output logic             q_init,
  output logic             shift_en,
  output logic             sub_ld,
  output logic             q_set,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             busy,
  output logic             done,
  output logic             ov,
  output logic             dbz
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_INIT   = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_TEST   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

  logic [2:0] state;
  logic [2:0] state_next;
  logic       last_iter;

  assign last_iter = (iter_cnt == LAST_ITER);

  // State register; unused encodings fall back to IDLE through next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection; abort outranks every other transition while busy.
  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_INIT;
        end
      end
      S_INIT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (b_zero) begin
          state_next = S_FINISH;
        end else begin
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_TEST;
        end
      end
      S_TEST: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (last_iter) begin
          state_next = S_FINISH;
        end else begin
          state_next = S_SHIFT;
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Iteration counter and sticky status flags; an aborted cycle leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt <= '0;
      ov       <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ov  <= 1'b0;
            dbz <= 1'b0;
          end
        end
        S_INIT: begin
          if (!abort) begin
            iter_cnt <= '0;
            if (b_zero) begin
              dbz <= 1'b1;
            end
          end
        end
        S_TEST: begin
          if (!abort && !last_iter) begin
            iter_cnt <= iter_cnt + CNT_W'(1);
          end
        end
        S_FINISH: begin
          // dbz was raised on entry to the divide-by-zero path; its quotient is meaningless.
          ov <= dbz ? 1'b0 : ov_in;
        end
        default: begin
          iter_cnt <= iter_cnt;
        end
      endcase
    end
  end

  // Strobe decode from state; an abort cycle suppresses the strobes so the datapath freezes.
  always_comb begin
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    acc_clr  = 1'b0;
    q_init   = 1'b0;
    shift_en = 1'b0;
    sub_ld   = 1'b0;
    q_set    = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD: begin
        ld_a = !abort;
        ld_b = !abort;
      end
      S_INIT: begin
        acc_clr = !abort;
        q_init  = !abort;
      end
      S_SHIFT: begin
        shift_en = !abort;
      end
      S_TEST: begin
        sub_ld = gT && !abort;
        q_set  = gT && !abort;
      end
      S_FINISH: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fixed_point_division_ctrl.sv
// Self-checking bench for fixed_point_division_ctrl: a table of whole
// operations followed by hand-written abort and mid-operation reset sequences.
module tb_fixed_point_division_ctrl;

  localparam int N_ITER = 14;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst, start, abort, b_zero, gT, ov_in;
  logic ld_a, ld_b, acc_clr, q_init, shift_en, sub_ld, q_set, busy, done, ov, dbz;
  logic [CNT_W-1:0] iter_cnt;

  int checks   = 0;
  int failures = 0;
  logic prev_ov  = 1'b0;
  logic prev_dbz = 1'b0;

  fixed_point_division_ctrl #(.N_ITER(N_ITER), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .b_zero(b_zero),
    .gT(gT), .ov_in(ov_in), .ld_a(ld_a), .ld_b(ld_b), .acc_clr(acc_clr),
    .q_init(q_init), .shift_en(shift_en), .sub_ld(sub_ld), .q_set(q_set),
    .iter_cnt(iter_cnt), .busy(busy), .done(done), .ov(ov), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic bz;        // b_zero presented for the whole operation
    int   mode;      // gT pattern: 0 never, 1 odd iterations, 2 always high
    logic ovin;      // ov_in held for the whole operation
    logic noise;     // extra start pulses in busy cycles 4..20
    int   done_cyc;  // expected done cycle (start sampled at cycle 0)
    int   shifts;    // expected shift_en pulses
    int   subs;      // expected sub_ld (and q_set) pulses
    logic ov;        // expected ov after done
    logic dbz;       // expected dbz after done
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic gt_for(input int mode, input int cyc);
    int i;
    if (mode == 2) return 1'b1;
    if (cyc < 4 || cyc[0]) return 1'b0;
    i = (cyc - 4) / 2;
    if (mode == 1) return i[0];
    return 1'b0;
  endfunction

  task automatic run_op(input vec_t v);
    int cyc, done_cyc, shifts, subs, qsets, busys, dones, itbad, stable;
    cyc = 0; done_cyc = 0; shifts = 0; subs = 0; qsets = 0;
    busys = 0; dones = 0; itbad = 0; stable = 1;
    @(negedge clk);
    #1;
    chk("pre_flags", {ov, dbz, busy}, {prev_ov, prev_dbz, 1'b0});
    start = 1'b1; b_zero = v.bz; ov_in = v.ovin; gT = gt_for(v.mode, 0);
    while (done_cyc == 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = v.noise && cyc >= 4 && cyc <= 20;
      gT = gt_for(v.mode, cyc);
      #1;
      if (cyc == 1) chk("load_cycle", {ld_a, ld_b, busy, ov, dbz}, 5'b11100);
      if (cyc == 2) chk("init_cycle", {acc_clr, q_init, shift_en}, 3'b110);
      if (!v.bz && cyc >= 4 && cyc <= 30 && !cyc[0])
        if (int'(iter_cnt) != (cyc - 4) / 2) itbad++;
      shifts += int'(shift_en);
      subs   += int'(sub_ld);
      qsets  += int'(q_set);
      busys  += int'(busy);
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
    start = 1'b0; gT = 1'b0;
    chk("done_cycle", done_cyc, v.done_cyc);
    chk("shift_count", shifts, v.shifts);
    chk("sub_count", subs, v.subs);
    chk("qset_count", qsets, v.subs);
    chk("busy_cycles", busys, v.done_cyc);
    chk("iter_index_errs", itbad, 0);
    repeat (10) begin
      @(negedge clk);
      #1;
      if (ov !== v.ov || dbz !== v.dbz || busy !== 1'b0) stable = 0;
      dones += int'(done);
    end
    chk("flags_after", {ov, dbz}, {v.ov, v.dbz});
    chk("flags_held_idle", stable, 1);
    chk("done_pulses", dones, 1);
    prev_ov = v.ov; prev_dbz = v.dbz;
  endtask

  vec_t vecs[5];

  initial begin
    int dones;
    vecs[0] = '{bz:1'b0, mode:0, ovin:1'b0, noise:1'b0, done_cyc:31, shifts:14, subs:0,  ov:1'b0, dbz:1'b0};
    vecs[1] = '{bz:1'b0, mode:1, ovin:1'b0, noise:1'b0, done_cyc:31, shifts:14, subs:7,  ov:1'b0, dbz:1'b0};
    vecs[2] = '{bz:1'b1, mode:0, ovin:1'b1, noise:1'b0, done_cyc:3,  shifts:0,  subs:0,  ov:1'b0, dbz:1'b1};
    vecs[3] = '{bz:1'b0, mode:2, ovin:1'b1, noise:1'b0, done_cyc:31, shifts:14, subs:14, ov:1'b1, dbz:1'b0};
    vecs[4] = '{bz:1'b0, mode:0, ovin:1'b0, noise:1'b1, done_cyc:31, shifts:14, subs:0,  ov:1'b0, dbz:1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; b_zero = 1'b0; gT = 1'b0; ov_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs",
        {ld_a, ld_b, acc_clr, q_init, shift_en, sub_ld, q_set, busy, done, ov, dbz, iter_cnt}, 0);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run_op(vecs[k]);

    // Abort in TEST at iteration 5 with gT high: strobes suppressed, back to IDLE, no done.
    @(negedge clk);
    start = 1'b1; b_zero = 1'b0; gT = 1'b1; ov_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_iter", int'(iter_cnt), 5);
    chk("abort_strobes", {shift_en, sub_ld, q_set, done, busy}, 5'b00001);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_exit", {busy, done, ov, dbz}, 4'b0000);
    chk("abort_iter_held", int'(iter_cnt), 5);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      dones += int'(done);
    end
    chk("abort_no_done", dones, 0);
    gT = 1'b0; ov_in = 1'b0;
    prev_ov = 1'b0; prev_dbz = 1'b0;

    // Asynchronous reset in TEST at iteration 9; outputs drop before the next edge.
    @(negedge clk);
    start = 1'b1; gT = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    #1;
    chk("pre_reset_iter", int'(iter_cnt), 9);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        {ld_a, ld_b, acc_clr, q_init, shift_en, sub_ld, q_set, busy, done, ov, dbz, iter_cnt}, 0);
    #1;
    rst = 1'b0; gT = 1'b0;
    run_op(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
